// File: rtl/apb_regfile_slave.sv
// APB register-file responder: read-only ID and STATUS words plus read/write storage,
// with programmable wait states, PSLVERR on bad accesses and saturating transfer counters.
module apb_regfile_slave #(
  parameter int unsigned SLAVE_ID    = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
  parameter int unsigned DEPTH       = 16,
  parameter int unsigned WAIT_CYCLES = 1,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic [2:0]  PSELx,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PADDR,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned WCW    = 4;
  localparam int unsigned NSTORE = DEPTH - 2;
  localparam logic [31:0]    SPAN        = 32'(4 * DEPTH);
  localparam logic [WCW-1:0] WAIT_INIT   = WCW'(WAIT_CYCLES);
  localparam logic [AW-1:0]  FIRST_STORE = AW'(2);
  localparam logic [1:0]     SEL_BIT     = 2'(SLAVE_ID);

  typedef enum logic {
    S_IDLE,
    S_ACCESS
  } state_e;

  state_e          state_q, state_d;
  logic [WCW-1:0]  wcnt_q, wcnt_d;
  logic [AW-1:0]   idx_q, idx_d;
  logic [31:0]     wdata_q, wdata_d;
  logic            write_q, write_d;
  logic            err_q, err_d;
  logic [15:0]     ok_cnt_q, ok_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  logic [31:0]     store_q [NSTORE];
  logic [31:0]     store_d [NSTORE];

  logic            sel_c;
  logic [31:0]     req_off_c;
  logic [AW-1:0]   req_idx_c;
  logic            req_err_c;
  logic            ready_c;
  logic [31:0]     rd_word_c;
  logic            unused_psel;

  assign sel_c       = PSELx[SEL_BIT];
  assign unused_psel = ^PSELx;

  // Decode of the address presented in the setup phase; wraps modulo 2^32.
  assign req_off_c = PADDR - BASE_ADDR;
  assign req_idx_c = req_off_c[AW+1:2];
  assign req_err_c = (PADDR[1:0] != 2'b00) | (PADDR < BASE_ADDR) | (req_off_c >= SPAN)
                   | (PWRITE & (req_idx_c < FIRST_STORE));

  assign ready_c = (state_q == S_ACCESS) && (wcnt_q == '0);

  always_comb begin
    rd_word_c = '0;
    if (idx_q == '0) begin
      rd_word_c = ID_VALUE;
    end else if (idx_q == AW'(1)) begin
      rd_word_c = {err_cnt_q, ok_cnt_q};
    end else begin
      rd_word_c = store_q[idx_q - FIRST_STORE];
    end
  end

  assign PREADY  = ready_c;
  assign PSLVERR = ready_c & err_q;
  assign PRDATA  = (ready_c & ~write_q & ~err_q) ? rd_word_c : '0;

  // Transfer sequencing, commit and counter update.
  always_comb begin
    state_d   = state_q;
    wcnt_d    = wcnt_q;
    idx_d     = idx_q;
    wdata_d   = wdata_q;
    write_d   = write_q;
    err_d     = err_q;
    ok_cnt_d  = ok_cnt_q;
    err_cnt_d = err_cnt_q;
    store_d   = store_q;
    case (state_q)
      S_IDLE: begin
        if (sel_c && !PENABLE) begin
          idx_d   = req_idx_c;
          wdata_d = PWDATA;
          write_d = PWRITE;
          err_d   = req_err_c;
          wcnt_d  = WAIT_INIT;
          state_d = S_ACCESS;
        end
      end
      S_ACCESS: begin
        if (sel_c && PENABLE) begin
          if (wcnt_q != '0) begin
            wcnt_d = wcnt_q - WCW'(1);
          end else begin
            state_d = S_IDLE;
            if (err_q) begin
              if (err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
            end else begin
              if (ok_cnt_q != '1) ok_cnt_d = ok_cnt_q + 16'd1;
              if (write_q) store_d[idx_q - FIRST_STORE] = wdata_q;
            end
          end
        end else begin
          // Master abandoned the transfer; a coincident setup phase is not taken.
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESETn) begin
    if (HRESETn) begin
      state_q   <= S_IDLE;
      wcnt_q    <= '0;
      idx_q     <= '0;
      wdata_q   <= '0;
      write_q   <= 1'b0;
      err_q     <= 1'b0;
      ok_cnt_q  <= '0;
      err_cnt_q <= '0;
      store_q   <= '{default: '0};
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      idx_q     <= idx_d;
      wdata_q   <= wdata_d;
      write_q   <= write_d;
      err_q     <= err_d;
      ok_cnt_q  <= ok_cnt_d;
      err_cnt_q <= err_cnt_d;
      store_q   <= store_d;
    end
  end

endmodule

// File: tb/tb_apb_regfile_slave.sv
// Randomized and directed bench for apb_regfile_slave: two responders on one APB bus
// (one wait state on select 0, none on select 1) checked against a word-level model.
module tb_apb_regfile_slave;

  localparam logic [31:0] BASE = 32'h8000_0000;
  localparam int unsigned NW   = 16;
  localparam logic [31:0] IDV  = 32'hA9B0_0001;

  logic        HCLK;
  logic        HRESETn;
  logic [2:0]  PSELx;
  logic        PENABLE;
  logic        PWRITE;
  logic [31:0] PADDR;
  logic [31:0] PWDATA;
  logic [31:0] prdata0, prdata1;
  logic        pready0, pready1;
  logic        pslverr0, pslverr1;

  int n_cmp = 0;
  int n_bad = 0;

  logic [31:0] mem_m [2][NW];
  int          ok_m  [2];
  int          err_m [2];

  apb_regfile_slave #(.SLAVE_ID(0), .BASE_ADDR(BASE), .DEPTH(NW), .WAIT_CYCLES(1), .ID_VALUE(IDV)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata0), .PREADY(pready0), .PSLVERR(pslverr0));

  apb_regfile_slave #(.SLAVE_ID(1), .BASE_ADDR(BASE), .DEPTH(NW), .WAIT_CYCLES(0), .ID_VALUE(IDV)) dut_nw (
    .HCLK(HCLK), .HRESETn(HRESETn), .PSELx(PSELx), .PENABLE(PENABLE), .PWRITE(PWRITE),
    .PADDR(PADDR), .PWDATA(PWDATA), .PRDATA(prdata1), .PREADY(pready1), .PSLVERR(pslverr1));

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic int wait_of(input int s);
    return (s == 0) ? 1 : 0;
  endfunction

  function automatic void model_reset();
    for (int s = 0; s < 2; s++) begin
      ok_m[s]  = 0;
      err_m[s] = 0;
      for (int w = 0; w < int'(NW); w++) mem_m[s][w] = '0;
    end
  endfunction

  // Word-level view of one completed transfer: returns expected data/error, then commits.
  function automatic void model_xfer(input int s, input bit wr, input logic [31:0] a,
                                     input logic [31:0] wd, output logic [31:0] rd, output bit er);
    logic [31:0] off;
    int          w;
    off = a - BASE;
    w   = 0;
    er  = (a % 4 != 0) || (a < BASE) || (off >= 4 * NW);
    if (!er) begin
      w  = int'(off / 4);
      er = wr && (w < 2);
    end
    rd = '0;
    if (!er && !wr) begin
      if (w == 0)      rd = IDV;
      else if (w == 1) rd = {16'(err_m[s]), 16'(ok_m[s])};
      else             rd = mem_m[s][w];
    end
    if (!er && wr) mem_m[s][w] = wd;
    if (er) err_m[s] = (err_m[s] == 65535) ? 65535 : err_m[s] + 1;
    else    ok_m[s]  = (ok_m[s]  == 65535) ? 65535 : ok_m[s]  + 1;
  endfunction

  function automatic logic ready_of(input int s);
    return (s == 0) ? pready0 : pready1;
  endfunction

  task automatic bus_idle();
    PSELx   = '0;
    PENABLE = 1'b0;
    @(negedge HCLK);
  endtask

  // Drives one APB transfer starting at a falling edge; returns at the falling edge after completion.
  task automatic apb_xfer(input int s, input bit wr, input logic [31:0] a, input logic [31:0] wd,
                          output logic [31:0] rd, output bit er, output int cyc);
    bit done;
    done    = 1'b0;
    rd      = '0;
    er      = 1'b0;
    PSELx   = 3'(1 << s);
    PENABLE = 1'b0;
    PWRITE  = wr;
    PADDR   = a;
    PWDATA  = wd;
    @(negedge HCLK);
    PENABLE = 1'b1;
    cyc     = 1;
    for (int k = 0; k < 20 && !done; k++) begin
      cyc++;
      check_eq("other_ready", 32'(ready_of(1 - s)), 32'd0);
      if (ready_of(s)) begin
        rd   = (s == 0) ? prdata0 : prdata1;
        er   = (s == 0) ? pslverr0 : pslverr1;
        done = 1'b1;
      end
      @(negedge HCLK);
    end
    if (!done) check_eq("ready_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_check(input int s, input bit wr, input logic [31:0] a,
                           input logic [31:0] wd, output logic [31:0] rd);
    logic [31:0] erd, grd;
    bit          eer, ger;
    int          cyc;
    model_xfer(s, wr, a, wd, erd, eer);
    apb_xfer(s, wr, a, wd, grd, ger, cyc);
    check_eq($sformatf("rdata s%0d %s %h", s, wr ? "wr" : "rd", a), grd, erd);
    check_eq($sformatf("pslverr s%0d %h", s, a), 32'(ger), 32'(eer));
    check_eq($sformatf("cycles s%0d", s), 32'(cyc), 32'(2 + wait_of(s)));
    rd = grd;
  endtask

  function automatic logic [31:0] rand_addr();
    logic [31:0] a;
    case ($urandom_range(0, 9))
      0:       a = BASE + 32'(4 * $urandom_range(0, NW - 1)) + 32'($urandom_range(1, 3));
      1:       a = BASE + 32'(4 * $urandom_range(NW, 40));
      2:       a = BASE - 32'(4 * $urandom_range(1, 8));
      default: a = BASE + 32'(4 * $urandom_range(0, NW - 1));
    endcase
    return a;
  endfunction

  initial begin
    logic [31:0] r;
    int          s;
    PSELx   = '0;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = '0;
    PWDATA  = '0;
    HRESETn = 1'b0;
    model_reset();
    #1 HRESETn = 1'b1;
    #1;
    check_eq("rst_pready0",  32'(pready0),  32'd0);
    check_eq("rst_pslverr0", 32'(pslverr0), 32'd0);
    check_eq("rst_prdata0",  prdata0,       32'd0);
    check_eq("rst_pready1",  32'(pready1),  32'd0);
    repeat (2) @(negedge HCLK);
    HRESETn = 1'b0;
    @(negedge HCLK);

    // Write then read back a storage word, then STATUS.
    run_check(0, 1'b1, 32'h8000_0008, 32'hDEAD_BEEF, r);
    run_check(0, 1'b0, 32'h8000_0008, '0, r);
    check_eq("readback", r, 32'hDEAD_BEEF);
    run_check(0, 1'b0, 32'h8000_0004, '0, r);
    check_eq("status_2ok", r, 32'h0000_0002);

    // ID word and a write to read-only STATUS.
    run_check(0, 1'b0, 32'h8000_0000, '0, r);
    check_eq("id_word", r, IDV);
    run_check(0, 1'b1, 32'h8000_0004, 32'h1234_5678, r);
    run_check(0, 1'b0, 32'h8000_0004, '0, r);
    check_eq("status_after_ro_wr", r, 32'h0001_0004);

    // Misaligned, out of range, below base.
    run_check(0, 1'b0, 32'h8000_0042, '0, r);
    run_check(0, 1'b1, 32'h8000_0040, 32'h5555_AAAA, r);
    run_check(0, 1'b0, 32'h7FFF_FFFC, '0, r);
    run_check(0, 1'b0, 32'h8000_0004, '0, r);
    check_eq("status_err4", r, 32'h0004_0005);
    bus_idle();

    // Back-to-back on the zero-wait responder.
    run_check(1, 1'b1, 32'h8000_0010, 32'hCAFE_F00D, r);
    run_check(1, 1'b0, 32'h8000_0010, '0, r);
    check_eq("b2b_data", r, 32'hCAFE_F00D);
    run_check(1, 1'b1, 32'h8000_003C, 32'h0BAD_C0DE, r);
    run_check(1, 1'b0, 32'h8000_0004, '0, r);
    check_eq("b2b_status", r, 32'h0000_0003);
    bus_idle();

    // Abort a write to word 5 during its wait state.
    PSELx   = 3'b001;
    PENABLE = 1'b0;
    PWRITE  = 1'b1;
    PADDR   = 32'h8000_0014;
    PWDATA  = 32'hFFFF_0000;
    @(negedge HCLK);
    check_eq("abort_wait_rdy", 32'(pready0), 32'd0);
    @(negedge HCLK);
    PSELx = '0;
    check_eq("abort_idle_rdy", 32'(pready0), 32'd0);
    @(negedge HCLK);
    run_check(0, 1'b0, 32'h8000_0014, '0, r);
    check_eq("abort_word5", r, 32'd0);
    bus_idle();

    // Randomized traffic on both responders.
    for (int i = 0; i < 120; i++) begin
      s = int'($urandom_range(0, 1));
      run_check(s, 1'($urandom_range(0, 1)), rand_addr(), $urandom, r);
      if ($urandom_range(0, 2) == 0) bus_idle();
    end
    bus_idle();

    // Reset asserted while PREADY is high.
    PSELx   = 3'b001;
    PENABLE = 1'b0;
    PWRITE  = 1'b0;
    PADDR   = 32'h8000_0000;
    @(negedge HCLK);
    PENABLE = 1'b1;
    @(negedge HCLK);
    check_eq("pre_rst_rdy", 32'(pready0), 32'd1);
    check_eq("pre_rst_data", prdata0, IDV);
    HRESETn = 1'b1;
    #1;
    check_eq("mid_rst_rdy", 32'(pready0), 32'd0);
    check_eq("mid_rst_data", prdata0, 32'd0);
    PSELx   = '0;
    PENABLE = 1'b0;
    @(negedge HCLK);
    HRESETn = 1'b0;
    model_reset();
    @(negedge HCLK);
    for (int w = 1; w < int'(NW); w++) begin
      run_check(0, 1'b0, BASE + 32'(4 * w), '0, r);
      run_check(1, 1'b0, BASE + 32'(4 * w), '0, r);
    end
    bus_idle();

    // Saturation of the good-transfer counter.
    force dut.ok_cnt_q = 16'hFFFE;
    #1 release dut.ok_cnt_q;
    ok_m[0] = 65534;
    run_check(0, 1'b0, 32'h8000_0008, '0, r);
    run_check(0, 1'b0, 32'h8000_0008, '0, r);
    run_check(0, 1'b1, 32'h8000_0001, '0, r);
    run_check(0, 1'b0, 32'h8000_0004, '0, r);
    check_eq("ok_saturated", r, 32'h0001_FFFF);
    bus_idle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/apb_regfile_slave.md
Name: apb_regfile_slave

Overview:
APB responder terminating one select line of the AHB-to-APB bridge's APB master. It decodes a word-aligned register window and holds a read-only ID word, a read-only status word and DEPTH-2 read/write storage words. It inserts a parameterised number of wait states via PREADY and flags bad accesses with PSLVERR. It keeps saturating counts of completed and errored transfers.

Parameters:
- SLAVE_ID, 0, index of PSELx bit that selects this slave (0..2)
- BASE_ADDR, 32'h8000_0000, byte address of word 0; must be 4-byte aligned
- DEPTH, 16, number of 32-bit words in the window (>=3, power of two)
- WAIT_CYCLES, 1, wait states inserted in each access phase (0..15)
- ID_VALUE, 32'hA9B0_0001, constant returned by word 0

Ports:
- HCLK  in  1  clock, rising edge
- HRESETn  in  1  reset; asynchronous, active-high
- PSELx  in  3  one-hot slave selects; this slave uses PSELx[SLAVE_ID]
- PENABLE  in  1  APB access-phase strobe
- PWRITE  in  1  1=write, 0=read
- PADDR  in  32  byte address
- PWDATA  in  32  write data
- PRDATA  out  32  read data; valid only when PREADY=1 and read
- PREADY  out  1  transfer completes this cycle
- PSLVERR  out  1  completing transfer is in error; valid only with PREADY=1

Behaviour:
- Reset and clock: reset is HRESETn, asynchronous, active-high. The clock is HCLK. While reset is high: state=IDLE, wait counter=0, all latches=0, storage words=0, both counters=0. PREADY, PSLVERR and PRDATA are all 0 immediately, with no clock edge required.
- Select: sel = PSELx[SLAVE_ID].
- Address decode, on latched address A:
  - off = A - BASE_ADDR; idx = off[log2(DEPTH)+1:2].
  - err = (A[1:0]!=0) | (A < BASE_ADDR) | (off >= 4*DEPTH) | (write & idx<2).
- Register map:
  - Word 0: ID_VALUE, read-only.
  - Word 1: STATUS, read-only. [15:0] = ok_cnt, [31:16] = err_cnt.
  - Words 2..DEPTH-1: read/write storage.
- States: IDLE, ACCESS.
- IDLE:
  - PREADY=0.
  - On an edge with sel=1 and PENABLE=0 (setup phase): latch PADDR, PWRITE, PWDATA; compute and latch err; wcnt <= WAIT_CYCLES; go to ACCESS.
  - sel=1 with PENABLE=1 while in IDLE is ignored and stays in IDLE.
- ACCESS:
  - PREADY = (wcnt==0). This is combinational from registers only; no input-to-output paths.
  - PSLVERR = PREADY & err_latched.
  - PRDATA = word[idx] when PREADY & ~write & ~err_latched; otherwise 0.
  - Edge with sel=1, PENABLE=1, wcnt!=0: wcnt decrements; stay in ACCESS.
  - Edge with sel=1, PENABLE=1, wcnt==0 (completion):
    - If write and no error: word[idx] <= latched PWDATA.
    - If err_latched: err_cnt increments. Otherwise ok_cnt increments. Both counters are 16-bit and saturate at 16'hFFFF.
    - Next state is IDLE. A back-to-back setup phase in the next cycle is then accepted normally.
  - Edge with sel=0 or PENABLE=0 before completion (master abort): no write, no counter update, go to IDLE. If that same cycle is a setup phase (sel=1, PENABLE=0), it is not accepted; the master must re-issue it.
- Latency: total transfer = 2 + WAIT_CYCLES cycles (setup + access + waits). With WAIT_CYCLES=0, PREADY is high in the first access cycle.
- A STATUS read returns the counter values before the current transfer's own increment.
- An errored write leaves storage unchanged. An errored read returns PRDATA=0.
- Address wrap: if BASE_ADDR+4*DEPTH overflows 32 bits, off is computed modulo 2^32; out-of-range is determined only by the off and A<BASE_ADDR checks.
- Reset asserted mid-transfer: the transfer is abandoned with no write and no count; PREADY drops asynchronously.

Test Plan:
- Write 32'hDEAD_BEEF to 32'h8000_0008, then read it back (WAIT_CYCLES=1) -> PREADY high in the 2nd access cycle of each transfer; read PRDATA=32'hDEAD_BEEF; PSLVERR=0; STATUS then reads 32'h0000_0002.
- Read 32'h8000_0000 -> PRDATA=32'hA9B0_0001. Write to 32'h8000_0004 -> PSLVERR=1 with PREADY, word 1 unchanged, err_cnt=1.
- Access 32'h8000_0042 (misaligned), 32'h8000_0040 (out of range, DEPTH=16) and 32'h7FFF_FFFC (below base) -> each completes with PSLVERR=1 and PRDATA=0; err_cnt increments by 3.
- Back-to-back write/read/write with no idle cycles, WAIT_CYCLES=0 -> each transfer is exactly 2 cycles; data is correct; ok_cnt=3.
- Deassert PENABLE during a wait state of a write to word 5 -> word 5 stays 0, counters unchanged, next transfer is accepted normally. Assert HRESETn mid-access -> PREADY=0 within the same cycle; all words and counters read 0 after release.
- Preload ok_cnt to 16'hFFFF (65535 good transfers), then one more good transfer -> ok_cnt stays 16'hFFFF, and err_cnt is not affected.
